vga_timing_checker: RTL and testbench

VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

---
 rtl/vga_timing_checker.sv | 131 +++++++++++++
 tb/tb_vga_timing_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_checker.sv
// VGA timing checker: measures line/hsync/active/frame timing on pixel strobes,
// keeps sticky error flags and locks after a clean frame.
//
// state  | meaning
// SEARCH | waiting for a vsync falling edge, no checking
// SYNC   | measuring, waiting for one clean frame
// LOCKED | timing verified, any bad frame drops back to SYNC
module vga_timing_checker #(
  parameter int H_TOTAL   = 800,
  parameter int H_VISIBLE = 640,
  parameter int HS_WIDTH  = 96,
  parameter int V_TOTAL   = 525,
  parameter int V_VISIBLE = 480
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blk,
  input  logic        clr_err,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [4:0]  err
);

  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] HS_W  = 11'(HS_WIDTH);
  localparam logic [10:0] H_TMO = 11'(2 * H_TOTAL);
  localparam logic [9:0]  V_TOT = 10'(V_TOTAL);
  localparam logic [9:0]  V_VIS = 10'(V_VISIBLE);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;
  state_t state, state_nxt;

  logic        hs_q, vs_q;
  logic [10:0] h_cnt, hs_low_cnt, act_cnt, h_inc;
  logic [9:0]  line_cnt, vis_cnt, line_nxt, vis_nxt;
  logic        frame_err;
  logic        hs_fall, hs_rise, vs_fall, checking, restart, frame_clean;
  logic [4:0]  new_err;

  assign hs_fall  = pix_en & hs_q & ~vga_hs;
  assign hs_rise  = pix_en & ~hs_q & vga_hs;
  assign vs_fall  = pix_en & vs_q & ~vga_vs;
  assign checking = (state != SEARCH);
  assign restart  = (state == SEARCH) & vs_fall;
  assign h_inc    = (h_cnt == 11'h7ff) ? h_cnt : h_cnt + 11'd1;

  // A line closed on the same strobe as vsync falls still belongs to the ending frame.
  assign line_nxt = line_cnt + {9'd0, hs_fall};
  assign vis_nxt  = vis_cnt + {9'd0, hs_fall & (act_cnt != 11'd0)};

  always_comb begin
    new_err    = '0;
    new_err[0] = checking & hs_fall & (h_cnt != H_TOT);
    new_err[1] = checking & hs_rise & (hs_low_cnt != HS_W);
    new_err[2] = checking & hs_fall & (act_cnt != 11'd0) & (act_cnt != H_VIS);
    new_err[3] = checking & vs_fall & ((line_nxt != V_TOT) | (vis_nxt != V_VIS));
    new_err[4] = checking & pix_en & ~hs_fall & (h_inc == H_TMO);
  end

  assign frame_clean = ~frame_err & ~(|new_err);

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (vs_fall) state_nxt = SYNC;
      SYNC: begin
        if (new_err[4])                state_nxt = SEARCH;
        else if (vs_fall && frame_clean) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (new_err[4])                 state_nxt = SEARCH;
        else if (vs_fall && !frame_clean) state_nxt = SYNC;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= SEARCH;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err         <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= vs_fall & checking;
      if (vs_fall && checking && frame_clean) frame_count <= frame_count + 16'd1;
      // a fresh error wins over a simultaneous clear
      err <= (clr_err ? 5'd0 : err) | new_err;
    end
  end

  // Measurement counters only move on pixel strobes; restart re-bases them at this strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      h_cnt      <= '0;
      hs_low_cnt <= '0;
      act_cnt    <= '0;
      line_cnt   <= '0;
      vis_cnt    <= '0;
      frame_err  <= 1'b0;
    end else if (pix_en) begin
      hs_q <= vga_hs;
      vs_q <= vga_vs;
      if (hs_fall)      h_cnt <= 11'd1;
      else if (restart) h_cnt <= '0;
      else              h_cnt <= h_inc;
      hs_low_cnt <= ((hs_rise || restart) ? 11'd0 : hs_low_cnt) + {10'd0, ~vga_hs};
      act_cnt    <= ((hs_fall || restart) ? 11'd0 : act_cnt) + {10'd0, vga_blk};
      if (vs_fall) begin
        line_cnt  <= '0;
        vis_cnt   <= '0;
        frame_err <= 1'b0;
      end else begin
        line_cnt  <= line_nxt;
        vis_cnt   <= vis_nxt;
        frame_err <= frame_err | (|new_err);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_checker.sv
// Scoreboard bench for vga_timing_checker: line-level reference model feeds
// expected status/frame events to a monitor that checks DUT output changes.
`timescale 1ns/1ps
module tb_vga_timing_checker;

  localparam int H_T = 40, H_V = 24, HS_W = 6, V_T = 20, V_V = 12;
  localparam int ACT0 = 10, TMO = 2 * H_T, MAX_LINES = 256;

  logic clk = 1'b0, nreset = 1'b1, pix_en = 1'b0;
  logic vga_hs = 1'b1, vga_vs = 1'b1, vga_blk = 1'b0, clr_err = 1'b0;
  logic locked, frame_done;
  logic [15:0] frame_count;
  logic [4:0] err;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_TOTAL(H_T), .H_VISIBLE(H_V), .HS_WIDTH(HS_W), .V_TOTAL(V_T), .V_VISIBLE(V_V)
  ) dut (
    .clk(clk), .nreset(nreset), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blk(vga_blk), .clr_err(clr_err), .locked(locked), .frame_done(frame_done),
    .frame_count(frame_count), .err(err)
  );

  typedef struct {
    int len; int hsw; int act; bit vs_low; int clr_pos; int rst_pos;
  } line_t;

  line_t lines [MAX_LINES];
  int    n_lines = 0;

  int n_cmp = 0, n_bad = 0;
  logic [5:0]  exp_st_q[$];
  logic [16:0] exp_fr_q[$];
  bit stim_done = 0, mon_on = 0;

  // reference model: frame-level view of lock state, sticky errors and count
  typedef enum int {M_SEARCH, M_SYNC, M_LOCKED} mstate_t;
  mstate_t    m_state = M_SEARCH;
  bit         m_hs = 1, m_vs = 1, dirty = 0;
  logic [4:0] m_err = '0;
  logic [15:0] m_count = '0;
  int         f_lines = 0, f_vis = 0;
  line_t      prev;
  logic [5:0] m_st_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT presented %0h with nothing expected at %0t", name, act, $time);
  endtask

  function automatic void push_status();
    logic [5:0] s;
    s = {m_state == M_LOCKED, m_err};
    if (s != m_st_last) begin
      exp_st_q.push_back(s);
      m_st_last = s;
    end
  endfunction

  function automatic void model_step(line_t ln, int p, bit hs, bit vs, bit clr);
    logic [4:0] nw;
    bit active, hs_fall, hs_rise, vs_fall, clean;
    nw      = '0;
    active  = (m_state != M_SEARCH);
    hs_fall = m_hs && !hs;
    hs_rise = !m_hs && hs;
    vs_fall = m_vs && !vs;
    if (hs_fall) begin
      if (active && prev.len != H_T) nw[0] = 1'b1;
      if (active && prev.act != 0 && prev.act != H_V) nw[2] = 1'b1;
      f_lines++;
      if (prev.act != 0) f_vis++;
    end
    if (hs_rise && active && ln.hsw != HS_W) nw[1] = 1'b1;
    if (!hs_fall && active && p + 1 == TMO) nw[4] = 1'b1;
    if (vs_fall && active && (f_lines != V_T || f_vis != V_V)) nw[3] = 1'b1;
    m_err = (clr ? 5'd0 : m_err) | nw;
    if (vs_fall) begin
      if (active) begin
        clean = !dirty && (nw == 5'd0);
        if (clean) m_count++;
        exp_fr_q.push_back({clean, m_count});
        m_state = clean ? M_LOCKED : M_SYNC;
      end else begin
        m_state = M_SYNC;
      end
      f_lines = 0;
      f_vis   = 0;
      dirty   = 0;
    end else if (nw != 5'd0) begin
      dirty = 1;
    end
    if (nw[4]) m_state = M_SEARCH;
    m_hs = hs;
    m_vs = vs;
    push_status();
  endfunction

  task automatic do_reset();
    pix_en  = 1'b0;
    clr_err = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    nreset  = 1'b0;
    m_state = M_SEARCH;
    m_err   = '0;
    m_count = '0;
    m_hs = 1; m_vs = 1; dirty = 0; f_lines = 0; f_vis = 0;
    push_status();
    #1;
    check("rst_locked", locked, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err", err, 0);
    repeat (3) begin @(posedge clk); #1; end
    nreset = 1'b1;
  endtask

  task automatic drive_line(input line_t ln);
    for (int p = 0; p < ln.len; p++) begin
      if (p == ln.rst_pos) do_reset();
      repeat ($urandom_range(0, 2)) begin
        pix_en  = 1'b0;
        clr_err = 1'b0;
        vga_hs  = 1'($urandom);
        vga_vs  = 1'($urandom);
        vga_blk = 1'($urandom);
        @(posedge clk); #1;
      end
      pix_en  = 1'b1;
      vga_hs  = (p < ln.hsw) ? 1'b0 : 1'b1;
      vga_vs  = ln.vs_low ? 1'b0 : 1'b1;
      vga_blk = (p >= ACT0 && p < ACT0 + ln.act);
      clr_err = (p == ln.clr_pos);
      model_step(ln, p, vga_hs, vga_vs, clr_err);
      @(posedge clk); #1;
    end
    pix_en  = 1'b0;
    clr_err = 1'b0;
    prev    = ln;
  endtask

  function automatic int add_frame(input int n);
    int base;
    base = n_lines;
    for (int l = 0; l < n; l++) begin
      lines[n_lines] = '{len: H_T, hsw: HS_W, act: (l >= 4 && l < 4 + V_V) ? H_V : 0,
                         vs_low: (l < 2), clr_pos: -1, rst_pos: -1};
      n_lines++;
    end
    return base;
  endfunction

  // monitor: pops expectations whenever the DUT changes status or ends a frame
  initial begin
    logic [5:0]  st, last_st, e_st;
    logic [16:0] e_fr;
    last_st = '0;
    wait (mon_on);
    while (!stim_done) begin
      @(negedge clk);
      st = {locked, err};
      if (st !== last_st) begin
        if (exp_st_q.size() == 0) fail_unexpected("status_change", 32'(st));
        else begin
          e_st = exp_st_q.pop_front();
          check("status_locked_err", 32'(st), 32'(e_st));
        end
        last_st = st;
      end
      if (frame_done === 1'b1) begin
        if (exp_fr_q.size() == 0) fail_unexpected("frame_done", 32'(frame_count));
        else begin
          e_fr = exp_fr_q.pop_front();
          check("frame_count", 32'(frame_count), 32'(e_fr[15:0]));
          check("locked_at_frame_end", 32'(locked), 32'(e_fr[16]));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    do_reset();
    mon_on = 1;
    b = add_frame(V_T);
    b = add_frame(V_T);
    b = add_frame(V_T);                                  // long line while locked
    lines[b + int'($urandom_range(5, 15))].len = H_T + 1;
    b = add_frame(V_T);
    b = add_frame(V_T);                                  // hsync width errors, clears
    lines[b + 3].hsw     = HS_W - 1;
    lines[b + 5].clr_pos = 20;
    lines[b + 7].act     = H_V - 1;
    lines[b + 9].hsw     = HS_W - 1;
    lines[b + 9].clr_pos = HS_W - 1;
    b = add_frame(V_T);
    b = add_frame(V_T);                                  // missing hsync -> timeout
    lines[b + 4].len = TMO + 10;
    b = add_frame(V_T);
    b = add_frame(V_T - 1);                              // short frame
    b = add_frame(V_T);
    b = add_frame(V_T);                                  // reset mid-line
    lines[b + 8].rst_pos = 17;
    b = add_frame(V_T);
    b = add_frame(1);
    for (int i = 0; i < n_lines; i++) drive_line(lines[i]);
    repeat (5) begin @(posedge clk); #1; end
    stim_done = 1;
    repeat (2) @(negedge clk);
    #1;
    check("status_queue_left", exp_st_q.size(), 0);
    check("frame_queue_left", exp_fr_q.size(), 0);
    check("final_locked", 32'(locked), 32'(m_state == M_LOCKED));
    check("final_frame_count", 32'(frame_count), 32'(m_count));
    check("final_err", 32'(err), 32'(m_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
